buzzer_beep_scheduler: RTL and testbench

Shares the single board buzzer between NUM_REQ key-event requesters, such as debounced key-detect pulses.
- Latches each request as pending.
- Grants requesters round-robin.
- For a grant to index i, plays i+1 beeps: on/off timed windows, then a silence gap.
- Drives the buzzer enable and a square-wave tone. Sits between the key-detect blocks and the buzzer pin.

---
 rtl/buzzer_beep_scheduler_pkg.sv | 36 +++
 rtl/buzzer_tone_gen.sv | 42 ++++
 rtl/buzzer_beep_scheduler.sv | 163 ++++++++++++++++
 tb/tb_buzzer_beep_scheduler.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/buzzer_beep_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// buzzer_beep_scheduler_pkg
//   Shared definitions for the buzzer beep scheduler slice:
//     - FSM state encodings (legacy numeric values kept)
//     - default timing constants for a 50 MHz CLK
//     - width helpers used to size counters from parameters
// -----------------------------------------------------------------------------
package buzzer_beep_scheduler_pkg;

    // FSM state encodings
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] BEEP_ON  = 2'd1;
    localparam logic [1:0] BEEP_OFF = 2'd2;
    localparam logic [1:0] GAP      = 2'd3;

    // Default timing at 50 MHz
    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_ON_CYCLES  = 5000000;   // 100 ms beep
    localparam int unsigned DEF_OFF_CYCLES = 5000000;   // 100 ms pause
    localparam int unsigned DEF_GAP_CYCLES = 10000000;  // 200 ms gap
    localparam int unsigned DEF_TONE_DIV   = 12500;     // 2 kHz tone

    // Counter width able to hold 0..v-1, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/buzzer_tone_gen.sv
// -----------------------------------------------------------------------------
// buzzer_tone_gen
//   Square-wave tone divider for the buzzer. While En is high the divider
//   counts 0..TONE_DIV-1 and toggles Tone at the terminal count. While En is
//   low the divider and Tone are forced to 0 so every beep starts low.
//
// Ports:
//   CLK   in   system clock, rising edge
//   RST   in   synchronous active-high reset
//   En    in   tone enable (beep-on window)
//   Tone  out  tone register
// -----------------------------------------------------------------------------
module buzzer_tone_gen
    import buzzer_beep_scheduler_pkg::*;
#(
    parameter int unsigned TONE_DIV = DEF_TONE_DIV
) (
    input  logic CLK,
    input  logic RST,
    input  logic En,
    output logic Tone
);

    localparam int unsigned          DIV_W    = cnt_width(TONE_DIV);
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(TONE_DIV - 1);
    localparam logic [DIV_W-1:0]     DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge CLK) begin
        if (RST || !En) begin
            div_cnt <= '0;
            Tone    <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            Tone    <= ~Tone;
        end else begin
            div_cnt <= div_cnt + DIV_ONE;
        end
    end

endmodule

// File: rtl/buzzer_beep_scheduler.sv
// -----------------------------------------------------------------------------
// buzzer_beep_scheduler
//   Shares one board buzzer between NUM_REQ key-event requesters. Each request
//   pulse is latched as pending; pending requesters are granted round-robin.
//   A grant to index g plays g+1 beeps (ON window, OFF window between beeps)
//   followed by a silence GAP. Sequences are never preempted.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST        in   synchronous active-high reset
//   Req_Sig    in   [NUM_REQ] request pulses, sampled every edge
//   Buzz_En    out  high during beep-on windows
//   Buzz_Out   out  tone to buzzer pin (Buzz_En & tone register)
//   Busy       out  high whenever the FSM is not IDLE
//   Grant_Vld  out  one-cycle pulse on the first BEEP_ON cycle of a sequence
//   Grant_Idx  out  [clog2(NUM_REQ)] current / last granted requester
// -----------------------------------------------------------------------------
module buzzer_beep_scheduler
    import buzzer_beep_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned ON_CYCLES  = DEF_ON_CYCLES,
    parameter int unsigned OFF_CYCLES = DEF_OFF_CYCLES,
    parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int unsigned TONE_DIV   = DEF_TONE_DIV
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_REQ-1:0]         Req_Sig,
    output logic                       Buzz_En,
    output logic                       Buzz_Out,
    output logic                       Busy,
    output logic                       Grant_Vld,
    output logic [$clog2(NUM_REQ)-1:0] Grant_Idx
);

    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned TMR_W  = cnt_width(max3(ON_CYCLES, OFF_CYCLES, GAP_CYCLES));
    localparam int unsigned BCNT_W = cnt_width(NUM_REQ + 1);

    localparam logic [TMR_W-1:0]   ON_LOAD  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0]   OFF_LOAD = TMR_W'(OFF_CYCLES - 1);
    localparam logic [TMR_W-1:0]   GAP_LOAD = TMR_W'(GAP_CYCLES - 1);
    localparam logic [TMR_W-1:0]   TMR_ONE  = TMR_W'(1);
    localparam logic [BCNT_W-1:0]  BCNT_ONE = BCNT_W'(1);
    localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] REQ_ONE  = NUM_REQ'(1);

    logic [1:0]         state;
    logic [NUM_REQ-1:0] pend;
    logic [IDX_W-1:0]   rr_ptr;
    logic [TMR_W-1:0]   timer;
    logic [BCNT_W-1:0]  beep_cnt;

    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic               grant_now;
    logic [NUM_REQ-1:0] clr_mask;
    logic               tone;

    // Round-robin search: first pending bit at or above rr_ptr, wrapping.
    always_comb begin
        int unsigned      cand;
        logic [IDX_W-1:0] cand_idx;
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!pick_vld && pend[cand_idx]) begin
                pick_vld = 1'b1;
                pick_idx = cand_idx;
            end
        end
    end

    assign grant_now = (state == IDLE) && pick_vld;
    assign clr_mask  = grant_now ? (REQ_ONE << pick_idx) : '0;

    // Clear before set so a request arriving on its own grant edge survives.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~clr_mask) | Req_Sig;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            timer     <= '0;
            beep_cnt  <= '0;
            Grant_Idx <= '0;
            Grant_Vld <= 1'b0;
        end else begin
            Grant_Vld <= grant_now;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        Grant_Idx <= pick_idx;
                        beep_cnt  <= BCNT_W'(pick_idx) + BCNT_ONE;
                        rr_ptr    <= (pick_idx == IDX_LAST) ? '0 : pick_idx + IDX_ONE;
                        timer     <= ON_LOAD;
                        state     <= BEEP_ON;
                    end
                end
                BEEP_ON: begin
                    if (timer == '0) begin
                        beep_cnt <= beep_cnt - BCNT_ONE;
                        if (beep_cnt == BCNT_ONE) begin
                            timer <= GAP_LOAD;
                            state <= GAP;
                        end else begin
                            timer <= OFF_LOAD;
                            state <= BEEP_OFF;
                        end
                    end else begin
                        timer <= timer - TMR_ONE;
                    end
                end
                BEEP_OFF: begin
                    if (timer == '0) begin
                        timer <= ON_LOAD;
                        state <= BEEP_ON;
                    end else begin
                        timer <= timer - TMR_ONE;
                    end
                end
                GAP: begin
                    if (timer == '0) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer - TMR_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Buzz_En = (state == BEEP_ON);
    assign Busy    = (state != IDLE);

    buzzer_tone_gen #(
        .TONE_DIV (TONE_DIV)
    ) u_tone (
        .CLK  (CLK),
        .RST  (RST),
        .En   (Buzz_En),
        .Tone (tone)
    );

    assign Buzz_Out = Buzz_En & tone;

endmodule

// File: tb/tb_buzzer_beep_scheduler.sv
// -----------------------------------------------------------------------------
// tb_buzzer_beep_scheduler
//   Self-checking bench for buzzer_beep_scheduler with small timing values.
//   A sequence-level model (pending flags, round-robin pointer, position t
//   inside the current sequence) predicts every output each cycle; directed
//   scenarios add literal expectations on grant order, busy lengths and tone.
// -----------------------------------------------------------------------------
module tb_buzzer_beep_scheduler;

    localparam int unsigned NREQ = 4;
    localparam int unsigned ON   = 4;
    localparam int unsigned OFF  = 3;
    localparam int unsigned GAPC = 5;
    localparam int unsigned TDIV = 2;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [NREQ-1:0] Req_Sig = '0;
    logic            Buzz_En, Buzz_Out, Busy, Grant_Vld;
    logic [1:0]      Grant_Idx;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    buzzer_beep_scheduler #(
        .NUM_REQ    (NREQ),
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF),
        .GAP_CYCLES (GAPC),
        .TONE_DIV   (TDIV)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Req_Sig   (Req_Sig),
        .Buzz_En   (Buzz_En),
        .Buzz_Out  (Buzz_Out),
        .Busy      (Busy),
        .Grant_Vld (Grant_Vld),
        .Grant_Idx (Grant_Idx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_valid  = 1'b0;
    bit m_active = 1'b0;
    int m_g = 0, m_t = 0, m_rr = 0, m_gidx = 0;
    bit m_pend [NREQ];

    function automatic int seq_len(input int g);
        return (g + 1) * ON + g * OFF + GAPC;
    endfunction

    function automatic bit exp_en();
        int p;
        if (!m_active) return 1'b0;
        if (m_t >= (m_g + 1) * ON + m_g * OFF) return 1'b0;
        p = m_t % (ON + OFF);
        return (p < ON);
    endfunction

    function automatic bit exp_out();
        int p;
        p = m_t % (ON + OFF);
        return exp_en() && (((p / TDIV) % 2) == 1);
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            m_g = 0; m_t = 0; m_rr = 0; m_gidx = 0;
            for (int i = 0; i < NREQ; i++) m_pend[i] = 1'b0;
        end else begin
            if (m_active) begin
                m_t++;
                if (m_t == seq_len(m_g)) m_active = 1'b0;
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    int c;
                    c = (m_rr + k) % NREQ;
                    if (!m_active && m_pend[c]) begin
                        m_active  = 1'b1;
                        m_g       = c;
                        m_gidx    = c;
                        m_t       = 0;
                        m_pend[c] = 1'b0;
                        m_rr      = (c + 1) % NREQ;
                    end
                end
            end
            for (int i = 0; i < NREQ; i++) if (Req_Sig[i]) m_pend[i] = 1'b1;
        end
    end

    always @(negedge CLK) begin
        if (m_valid) begin
            check("Busy",      Busy,      m_active);
            check("Buzz_En",   Buzz_En,   exp_en());
            check("Buzz_Out",  Buzz_Out,  exp_out());
            check("Grant_Vld", Grant_Vld, m_active && (m_t == 0));
            check("Grant_Idx", Grant_Idx, m_gidx);
        end
    end

    // ---------------- activity log for directed checks ----------------
    int cyc = 0;
    bit busy_prev = 1'b0;
    int rise_q[$], fall_q[$], gnt_q[$];
    int en_cnt = 0;

    always @(negedge CLK) begin
        cyc++;
        if (Busy && !busy_prev) rise_q.push_back(cyc);
        if (!Busy && busy_prev) fall_q.push_back(cyc);
        busy_prev = Busy;
        if (Grant_Vld) gnt_q.push_back(int'(Grant_Idx));
        if (Buzz_En) en_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse(input logic [NREQ-1:0] m);
        Req_Sig = m;
        @(negedge CLK);
        Req_Sig = '0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        rise_q.delete();
        fall_q.delete();
        gnt_q.delete();
        en_cnt = 0;
    endtask

    task automatic wait_grant();
        bit found;
        found = Grant_Vld;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge CLK);
            found = Grant_Vld;
        end
        check("grant_wait", found, 1);
    endtask

    task automatic check_runs(input string name, input int exp_g[], input int exp_len[]);
        check({name, "_ngrant"}, gnt_q.size(), exp_g.size());
        check({name, "_nbusy"},  fall_q.size(), exp_len.size());
        if (gnt_q.size() == exp_g.size())
            foreach (exp_g[i]) check({name, "_gidx"}, gnt_q[i], exp_g[i]);
        if (fall_q.size() == exp_len.size() && rise_q.size() == exp_len.size()) begin
            foreach (exp_len[i]) check({name, "_busylen"}, fall_q[i] - rise_q[i], exp_len[i]);
            for (int i = 0; i + 1 < exp_len.size(); i++)
                check({name, "_idlegap"}, rise_q[i+1] - fall_q[i], 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_tone [4];
        exp_tone = '{0, 0, 1, 1};

        // Reset state
        tick(2);
        RST = 1'b0;
        check("rst_Busy",      Busy,      0);
        check("rst_Buzz_En",   Buzz_En,   0);
        check("rst_Grant_Idx", Grant_Idx, 0);
        check("rst_Grant_Vld", Grant_Vld, 0);

        // 1: single request idx 2 -> 3 beeps, busy 23 cycles
        do_reset();
        pulse(4'b0100);
        tick(40);
        check_runs("t1", '{2}, '{23});
        check("t1_on_cycles", en_cnt, 12);

        // 2: all four at once -> grants 0..3
        do_reset();
        pulse(4'b1111);
        tick(100);
        check_runs("t2", '{0, 1, 2, 3}, '{9, 16, 23, 30});

        // 3: repeated pulses on idx 1 merge into one request
        do_reset();
        pulse(4'b0001);
        tick(1);
        pulse(4'b0010);
        tick(1);
        pulse(4'b0010);
        tick(1);
        pulse(4'b0010);
        tick(40);
        check_runs("t3", '{0, 1}, '{9, 16});

        // 4: reset during the second beep of idx 1
        do_reset();
        pulse(4'b0010);
        wait_grant();
        tick(ON + OFF);
        check("t4_second_on", Buzz_En, 1);
        RST = 1'b1;
        @(negedge CLK);
        check("t4_Buzz_En",   Buzz_En,   0);
        check("t4_Busy",      Busy,      0);
        check("t4_Buzz_Out",  Buzz_Out,  0);
        check("t4_Grant_Idx", Grant_Idx, 0);
        RST = 1'b0;
        tick(40);
        check("t4_ngrant", gnt_q.size(), 1);
        check("t4_on_cycles", en_cnt, ON + 1);

        // 5: tone phase for idx 0
        do_reset();
        pulse(4'b0001);
        wait_grant();
        for (int i = 0; i < ON; i++) begin
            check("t5_tone_on", Buzz_Out, exp_tone[i]);
            tick(1);
        end
        for (int i = 0; i < GAPC; i++) begin
            check("t5_gap_busy", Busy, 1);
            check("t5_tone_gap", Buzz_Out, 0);
            tick(1);
        end
        check("t5_idle", Busy, 0);

        // 6: idx 0 re-requests during its own beep
        do_reset();
        pulse(4'b0001);
        wait_grant();
        pulse(4'b0001);
        tick(30);
        check_runs("t6", '{0, 0}, '{9, 9});

        // Random traffic with occasional resets, checked against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [NREQ-1:0] r;
            r = '0;
            for (int b = 0; b < NREQ; b++)
                if ($urandom_range(0, 99) < 3) r[b] = 1'b1;
            Req_Sig = r;
            RST = ($urandom_range(0, 999) == 0);
            @(negedge CLK);
        end
        Req_Sig = '0;
        RST = 1'b0;
        tick(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
